// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM states, opcodes, datapath select encodings.
// Pure declarations, no logic or latency.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle sequencer.
// master = datapath side (drives IR fields, flags, mem_ready); slave = controller.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal;

    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, instr_done, illegal
    );

    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALUOp + funct fields -> ALUControl; purely combinational, no backpressure.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        unique case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only selects sub for register ops; addi keeps it as imm bit
                    3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: lw 5, sw/R/I/jal 4, branch 3 cycles with mem_ready high.
// mem_ready low stalls FETCH/MEMREAD/MEMWRITE one cycle per low cycle; rst zeroes all outputs at once.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.slave bus
);
    state_t     state_q, state_d;
    logic       rdy;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
    logic [1:0] res_src, src_a, src_b, imm_src;
    alu_op_t    alu_op;
    logic [2:0] alu_ctrl;

    assign rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        res_src    = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        unique case (state_q)
            S_FETCH: begin
                src_b   = SRCB_FOUR;
                res_src = RES_ALURESULT;
                if (rdy) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // precompute branch target into ALUOut
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RALU:      state_d = S_EXECUTER;
                    OP_IALU:      state_d = S_EXECUTEI;
                    OP_BRANCH:    state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res_src    = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (rdy) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                src_a   = SRCA_RS1;
                src_b   = (state_q == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                src_a      = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                pc_write   = bus.zero ^ bus.funct3[0];
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while ALU forms OldPC+4 for rd
                src_a    = SRCA_OLDPC;
                src_b    = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:     imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.op[5]),
        .alu_control (alu_ctrl)
    );

    assign bus.PCWrite    = pc_write   & ~rst;
    assign bus.AdrSrc     = adr_src    & ~rst;
    assign bus.MemWrite   = mem_write  & ~rst;
    assign bus.IRWrite    = ir_write   & ~rst;
    assign bus.RegWrite   = reg_write  & ~rst;
    assign bus.instr_done = instr_done & ~rst;
    assign bus.illegal    = illegal    & ~rst;
    assign bus.ResultSrc  = rst ? 2'b00 : res_src;
    assign bus.ALUSrcA    = rst ? 2'b00 : src_a;
    assign bus.ALUSrcB    = rst ? 2'b00 : src_b;
    assign bus.ImmSrc     = rst ? 2'b00 : imm_src;
    assign bus.ALUControl = rst ? ALU_ADD : alu_ctrl;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle traces built from the instruction-level rules, replayed and compared each cycle.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst, rdy, zero, f7;
        logic [6:0] op;
        logic [2:0] f3;
        logic       pcw, adr, memw, irw, regw, done, ill;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] aluc;
    } cyc_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RA = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    localparam logic N = 1'b0, Y = 1'b1;

    cyc_t plan[$];
    cyc_t expq[$];
    cyc_t ce;
    int   nchk = 0, nerr = 0, cyc = 0, emit_left = 0;
    logic [6:0] c_op = 7'd0;
    logic [2:0] c_f3 = 3'd0;
    logic       c_f7 = 1'b0, c_z = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [1:0] imm_model(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BR) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    // Operation chosen by funct3; only register-register ops may turn add into sub
    function automatic logic [2:0] alu_model(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        if (f3 == 3'd0) return (f7 && op == RA) ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic rr();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] pack(input logic pcw, adr, memw, irw, input logic [1:0] res, sa, sb,
                                         input logic [2:0] aluc, input logic [1:0] imm, input logic regw, done, ill);
        return {14'd0, pcw, adr, memw, irw, res, sa, sb, aluc, imm, regw, done, ill};
    endfunction

    task automatic emit(input logic rdy, pcw, adr, memw, irw, input logic [1:0] res, sa, sb,
                        input logic [2:0] aluc, input logic regw, done, ill);
        cyc_t e;
        if (emit_left <= 0) return;
        emit_left--;
        e.rst = 1'b0; e.rdy = rdy; e.zero = c_z; e.f7 = c_f7; e.op = c_op; e.f3 = c_f3;
        e.pcw = pcw; e.adr = adr; e.memw = memw; e.irw = irw; e.regw = regw; e.done = done; e.ill = ill;
        e.res = res; e.sa = sa; e.sb = sb; e.aluc = aluc; e.imm = imm_model(c_op);
        plan.push_back(e);
    endtask

    task automatic emit_rst(input logic rdy);
        cyc_t e;
        e.rst = 1'b1; e.rdy = rdy; e.zero = c_z; e.f7 = c_f7; e.op = c_op; e.f3 = c_f3;
        e.pcw = N; e.adr = N; e.memw = N; e.irw = N; e.regw = N; e.done = N; e.ill = N;
        e.res = 2'd0; e.sa = 2'd0; e.sb = 2'd0; e.aluc = 3'd0; e.imm = 2'd0;
        plan.push_back(e);
    endtask

    // Whole-instruction trace: wf fetch stalls, wm memory stalls, at most maxc cycles emitted
    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, z,
                             input int wf, wm, maxc);
        logic legal;
        c_op = op; c_f3 = f3; c_f7 = f7; c_z = z; emit_left = maxc;
        legal = (op == LW || op == SW || op == RA || op == IA || op == BR || op == JL);
        repeat (wf) emit(N, N, N, N, N, 2'd2, 2'd0, 2'd2, 3'd0, N, N, N);
        emit(Y, Y, N, N, Y, 2'd2, 2'd0, 2'd2, 3'd0, N, N, N);
        emit(rr(), N, N, N, N, 2'd0, 2'd1, 2'd1, 3'd0, N, N, !legal);
        if (op == LW) begin
            emit(rr(), N, N, N, N, 2'd0, 2'd2, 2'd1, 3'd0, N, N, N);
            repeat (wm) emit(N, N, Y, N, N, 2'd0, 2'd0, 2'd0, 3'd0, N, N, N);
            emit(Y, N, Y, N, N, 2'd0, 2'd0, 2'd0, 3'd0, N, N, N);
            emit(rr(), N, N, N, N, 2'd1, 2'd0, 2'd0, 3'd0, Y, Y, N);
        end else if (op == SW) begin
            emit(rr(), N, N, N, N, 2'd0, 2'd2, 2'd1, 3'd0, N, N, N);
            repeat (wm) emit(N, N, Y, Y, N, 2'd0, 2'd0, 2'd0, 3'd0, N, N, N);
            emit(Y, N, Y, Y, N, 2'd0, 2'd0, 2'd0, 3'd0, N, Y, N);
        end else if (op == RA || op == IA) begin
            emit(rr(), N, N, N, N, 2'd0, 2'd2, (op == IA) ? 2'd1 : 2'd0, alu_model(op, f3, f7), N, N, N);
            emit(rr(), N, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, Y, Y, N);
        end else if (op == BR) begin
            emit(rr(), z ^ f3[0], N, N, N, 2'd0, 2'd2, 2'd0, 3'b001, N, Y, N);
        end else if (op == JL) begin
            emit(rr(), Y, N, N, N, 2'd0, 2'd1, 2'd2, 3'd0, N, N, N);
            emit(rr(), N, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, Y, Y, N);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (expq.size() > 0) begin
            ce = expq.pop_front();
            chk($sformatf("cycle%0d_outputs", cyc),
                pack(bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
                     bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegWrite, bus.instr_done, bus.illegal),
                pack(ce.pcw, ce.adr, ce.memw, ce.irw, ce.res, ce.sa, ce.sb, ce.aluc, ce.imm,
                     ce.regw, ce.done, ce.ill));
            cyc++;
        end
    end

    initial begin
        int n0;
        logic [6:0] ops [7];
        logic [6:0] o;
        logic [2:0] f;
        ops = '{LW, SW, RA, IA, BR, JL, 7'b1111111};
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        emit_rst(Y);
        emit_rst(Y);

        n0 = plan.size(); gen_instr(LW, 3'd2, N, N, 0, 0, 99);
        chk("model_lw_cycles", 32'(plan.size() - n0), 32'd5);
        n0 = plan.size(); gen_instr(SW, 3'd2, N, N, 0, 3, 99);
        chk("model_sw_3stall_cycles", 32'(plan.size() - n0), 32'd7);
        n0 = plan.size(); gen_instr(RA, 3'd0, Y, N, 0, 0, 99);
        chk("model_r_cycles", 32'(plan.size() - n0), 32'd4);
        n0 = plan.size(); gen_instr(IA, 3'd0, Y, N, 0, 0, 99);
        chk("model_i_cycles", 32'(plan.size() - n0), 32'd4);
        n0 = plan.size(); gen_instr(BR, 3'd0, N, Y, 0, 0, 99);
        chk("model_beq_cycles", 32'(plan.size() - n0), 32'd3);
        chk("model_beq_taken", 32'(plan[plan.size() - 1].pcw), 32'd1);
        gen_instr(BR, 3'd1, N, Y, 0, 0, 99);
        chk("model_bne_not_taken", 32'(plan[plan.size() - 1].pcw), 32'd0);
        n0 = plan.size(); gen_instr(JL, 3'd0, N, N, 1, 0, 99);
        chk("model_jal_1stall_cycles", 32'(plan.size() - n0), 32'd5);
        n0 = plan.size(); gen_instr(7'b1111111, 3'd0, N, N, 0, 0, 99);
        chk("model_illegal_cycles", 32'(plan.size() - n0), 32'd2);
        chk("model_alu_sub", 32'(alu_model(RA, 3'd0, Y)), 32'b001);
        chk("model_alu_addi", 32'(alu_model(IA, 3'd0, Y)), 32'b000);
        chk("model_imm_store", 32'(imm_model(SW)), 32'b01);

        // abort a store while it is stalled in the write state, then restart cleanly
        gen_instr(SW, 3'd2, N, N, 0, 5, 6);
        emit_rst(Y);
        gen_instr(RA, 3'd7, N, N, 0, 0, 99);

        repeat (150) begin
            o = ops[$urandom_range(0, 6)];
            if (o == 7'b1111111) o = 7'($urandom_range(0, 127));
            f = (o == BR) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 11) == 0) begin
                gen_instr(o, f, rr(), rr(), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 6));
                emit_rst(rr());
            end else begin
                gen_instr(o, f, rr(), rr(), $urandom_range(0, 2), $urandom_range(0, 3), 99);
            end
        end

        foreach (plan[i]) begin
            @(negedge clk);
            rst = plan[i].rst;
            bus.mem_ready = plan[i].rdy;
            bus.op = plan[i].op;
            bus.funct3 = plan[i].f3;
            bus.funct7b5 = plan[i].f7;
            bus.zero = plan[i].zero;
            expq.push_back(plan[i]);
        end
        @(negedge clk);
        @(negedge clk);
        #5;
        if (expq.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL trace_drain: got %0d unchecked cycles expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
